// File: rtl/read_empty_level.sv
// Read-domain control for the async FIFO: write-pointer synchroniser, read pointer
// (binary + Gray), registered empty / almost-empty / level and a sticky underflow flag.
module read_empty_level #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_THRESH   = 2
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              r_en,
  input  logic [ADDR_W:0]   write_addr_gray,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] read_addr,
  output logic [ADDR_W:0]   read_addr_gray,
  output logic              read_fire,
  output logic              flag_empty,
  output logic              flag_almost_empty,
  output logic [ADDR_W:0]   read_level,
  output logic              err_underflow
);

  localparam int unsigned PW = ADDR_W + 1;
  localparam logic [PW-1:0] AeThresh = PW'(AE_THRESH);

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wsync;
  logic [PW-1:0] wbin;
  logic [PW-1:0] rbin_q;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] lvl_next;
  logic [PW-1:0] rgray_q;
  logic [PW-1:0] level_q;
  logic          empty_q;
  logic          almost_empty_q;
  logic          err_q;

  assign wsync = sync_q[SYNC_STAGES-1];

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin = '0;
    for (int i = 0; i < int'(PW); i++) begin
      wbin[i] = ^(wsync >> i);
    end
  end

  // No pop is accepted while reset is being applied.
  assign read_fire  = r_en & ~empty_q & ~r_rst;
  assign rbin_next  = rbin_q + {{ADDR_W{1'b0}}, read_fire};
  assign rgray_next = rbin_next ^ (rbin_next >> 1);
  // Level uses the synchronised (stale) write pointer, so it can only understate.
  assign lvl_next   = wbin - rbin_next;

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
      rbin_q         <= '0;
      rgray_q        <= '0;
      level_q        <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      err_q          <= 1'b0;
    end else begin
      sync_q[0] <= write_addr_gray;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      rbin_q         <= rbin_next;
      rgray_q        <= rgray_next;
      level_q        <= lvl_next;
      empty_q        <= (rgray_next == wsync);
      almost_empty_q <= (lvl_next <= AeThresh);
      // Set has priority over clear.
      if (r_en && empty_q) begin
        err_q <= 1'b1;
      end else if (clr_err) begin
        err_q <= 1'b0;
      end
    end
  end

  assign read_addr         = rbin_q[ADDR_W-1:0];
  assign read_addr_gray    = rgray_q;
  assign flag_empty        = empty_q;
  assign flag_almost_empty = almost_empty_q;
  assign read_level        = level_q;
  assign err_underflow     = err_q;

endmodule

// File: tb/tb_read_empty_level.sv
// Randomised bench for read_empty_level: a count-based FIFO model (total writes/reads,
// write count delayed through a queue) predicts every output each cycle.
module tb_read_empty_level;

  logic       r_clk = 1'b0;
  logic       r_rst;
  logic       r_en;
  logic [4:0] write_addr_gray;
  logic       clr_err;
  logic [3:0] read_addr;
  logic [4:0] read_addr_gray;
  logic       read_fire;
  logic       flag_empty;
  logic       flag_almost_empty;
  logic [4:0] read_level;
  logic       err_underflow;

  read_empty_level #(
    .ADDR_W     (4),
    .SYNC_STAGES(2),
    .AE_THRESH  (2)
  ) dut (
    .r_clk            (r_clk),
    .r_rst            (r_rst),
    .r_en             (r_en),
    .write_addr_gray  (write_addr_gray),
    .clr_err          (clr_err),
    .read_addr        (read_addr),
    .read_addr_gray   (read_addr_gray),
    .read_fire        (read_fire),
    .flag_empty       (flag_empty),
    .flag_almost_empty(flag_almost_empty),
    .read_level       (read_level),
    .err_underflow    (err_underflow)
  );

  always #5 r_clk = ~r_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: unbounded counts of writes and reads; pointers are counts modulo 2**5.
  int wcnt;
  int m_rcnt;
  int m_lvl;
  bit m_empty;
  bit m_err;
  int hist[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int gray5(input int cnt);
    int b;
    b = cnt % 32;
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_rcnt  = 0;
    m_lvl   = 0;
    m_empty = 1'b1;
    m_err   = 1'b0;
    hist.delete();
    hist.push_back(0);
    hist.push_back(0);
  endtask

  // Drive inputs, compare everything, then advance one rise and update the model.
  task automatic step(input bit rst, input bit en, input bit clr);
    bit fire;
    int wsync_cnt;
    @(negedge r_clk);
    r_rst           = rst;
    r_en            = en;
    clr_err         = clr;
    write_addr_gray = 5'(gray5(wcnt));
    #1;
    fire = en && !m_empty && !rst;
    check_eq("read_fire", int'(read_fire), int'(fire));
    check_eq("read_addr", int'(read_addr), m_rcnt % 16);
    check_eq("read_addr_gray", int'(read_addr_gray), gray5(m_rcnt));
    check_eq("flag_empty", int'(flag_empty), int'(m_empty));
    check_eq("flag_almost_empty", int'(flag_almost_empty), int'(m_lvl <= 2));
    check_eq("read_level", int'(read_level), m_lvl);
    check_eq("err_underflow", int'(err_underflow), int'(m_err));
    @(posedge r_clk);
    if (rst) begin
      model_reset();
    end else begin
      wsync_cnt = hist[0];
      if (en && m_empty) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
      m_rcnt += int'(fire);
      m_lvl   = wsync_cnt - m_rcnt;
      m_empty = (m_lvl == 0);
      void'(hist.pop_front());
      hist.push_back(wcnt);
    end
  endtask

  initial begin
    r_rst = 1'b1;
    r_en = 1'b0;
    clr_err = 1'b0;
    write_addr_gray = '0;
    wcnt = 0;
    model_reset();
    // Reset: two rises; reset state is compared at the start of the next step.
    @(posedge r_clk);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Sync latency: one write becomes visible on exactly the third rise.
    wcnt = 1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_eq("lat_level_2rises", int'(read_level), 0);
    step(1'b0, 1'b0, 1'b0);
    #1;
    check_eq("lat_level_3rises", int'(read_level), 1);
    check_eq("lat_empty_3rises", int'(flag_empty), 0);
    check_eq("lat_ae_3rises", int'(flag_almost_empty), 1);

    // Drain past empty to raise underflow, then clear it.
    wcnt = 5;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Random traffic with occasional reset; covers wraps and threshold crossings.
    for (int i = 0; i < 4000; i++) begin
      bit rst;
      rst = ($urandom_range(0, 299) == 0);
      if (rst) begin
        wcnt = 0;
      end else if ($urandom_range(0, 99) < 50 && (wcnt - m_rcnt) < 16) begin
        wcnt++;
      end
      step(rst, ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 10));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
